sram_1w_nr_init: RTL and testbench

- Parametrised successor to the team's 2-port SRAM: one write port, NRD independent read ports, all on a single clock.
- Adds per-byte write enables, a selectable same-address collision mode, and a hardware init state machine that zero-fills the array after reset or on request.
- Sits as register-file / scratch storage behind the datapath, replacing ad-hoc SRAM instances where multiple simultaneous reads are needed.

---
 rtl/sram_1w_nr_init.sv | 141 ++++++++++++++
 tb/tb_sram_1w_nr_init.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1w_nr_init.sv
// sram_1w_nr_init: 1-write / NRD-read synchronous SRAM with byte enables, collision mode and zero-fill init FSM
//   clk, rst (async, active-high) | init_req -> busy
//   write: wen, waddr, wbe, wdata | read: ren[NRD], raddr[NRD*ADDR_W] -> rdata[NRD*DATA_W], rvalid[NRD]
//   `define SRAM_PARITY_EN adds per-byte even parity, input perr_inject and output rperr[NRD]
module sram_1w_nr_init #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 6,
    parameter int NRD       = 2,
    parameter int WT_BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_req,
    output logic                  busy,
    input  logic                  wen,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W/8-1:0]   wbe,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [NRD-1:0]        ren,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rvalid
`ifdef SRAM_PARITY_EN
    ,
    input  logic                  perr_inject,
    output logic [NRD-1:0]        rperr
`endif
);
    localparam int NB = DATA_W / 8;
`ifdef SRAM_PARITY_EN
    localparam int MW = DATA_W + NB;
`else
    localparam int MW = DATA_W;
`endif
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    if (DATA_W % 8 != 0 || DEPTH < 2 || DEPTH > 2**ADDR_W || NRD < 1 || NRD > 4) begin : g_bad
        $error("sram_1w_nr_init: illegal parameters");
    end

    typedef enum logic {INIT, READY} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                ready, we;
    logic [MW-1:0]       mem [DEPTH];
    logic [MW-1:0]       wr_word;
    logic [MW-1:0]       rd_word [NRD];
    logic [NRD-1:0]      rd_ok, rd_hit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST) begin
                state_d = READY;
                cnt_d   = '0;
            end
        end else if (init_req) begin
            state_d = INIT;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready = state_q == READY;
    assign busy  = !ready;
    assign we    = ready && wen && ({1'b0, waddr} < DEPTH_L);

    // Word as it looks after the write: enabled bytes from wdata, the rest from the array.
    // The same word feeds the write-through bypass.
    always_comb begin
        wr_word = mem[waddr];
        for (int b = 0; b < NB; b++) begin
            if (wbe[b]) begin
                wr_word[8*b +: 8] = wdata[8*b +: 8];
`ifdef SRAM_PARITY_EN
                wr_word[DATA_W+b] = ^wdata[8*b +: 8] ^ perr_inject;
`endif
            end
        end
    end

    // Contents are not reset; INIT zero-fills one word per cycle.
    always_ff @(posedge clk) begin
        if (!ready)
            mem[cnt_q] <= '0;
        else if (we)
            mem[waddr] <= wr_word;
    end

    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            rd_ok[p]   = {1'b0, raddr[p*ADDR_W +: ADDR_W]} < DEPTH_L;
            rd_hit[p]  = (WT_BYPASS != 0) && ready && wen && raddr[p*ADDR_W +: ADDR_W] == waddr;
            rd_word[p] = !rd_ok[p] ? '0 : rd_hit[p] ? wr_word : mem[raddr[p*ADDR_W +: ADDR_W]];
        end
    end

`ifdef SRAM_PARITY_EN
    logic [NRD-1:0] rd_perr;
    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            rd_perr[p] = 1'b0;
            for (int b = 0; b < NB; b++)
                rd_perr[p] = rd_perr[p] | (^rd_word[p][8*b +: 8] ^ rd_word[p][DATA_W+b]);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= '0;
`ifdef SRAM_PARITY_EN
            rperr  <= '0;
`endif
        end else begin
            for (int p = 0; p < NRD; p++) begin
                rvalid[p] <= ready && ren[p];
                if (ready && ren[p])
                    rdata[p*DATA_W +: DATA_W] <= rd_word[p][DATA_W-1:0];
`ifdef SRAM_PARITY_EN
                rperr[p] <= ready && ren[p] && rd_perr[p];
`endif
            end
        end
    end
endmodule

// File: tb/tb_sram_1w_nr_init.sv
// tb_sram_1w_nr_init: randomized + directed check of two sram_1w_nr_init builds against an array-level model
module tb_sram_1w_nr_init;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        init_req = 1'b0;
    logic        wen = 1'b0;
    logic [5:0]  waddr = '0;
    logic [3:0]  wbe = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  ren = '0;
    logic [11:0] raddr = '0;
    logic        perr_inject = 1'b0;
    logic        busy_o [2];
    logic [63:0] rdata_o [2];
    logic [1:0]  rvalid_o [2];
    logic [1:0]  rperr_o [2];

    int checks = 0;
    int errors = 0;
    int n;

    // model: instance 0 is write-through with 64 words, instance 1 is read-old with 48 words
    int          dep [2] = '{64, 48};
    bit          byp [2] = '{1'b1, 1'b0};
    logic [31:0] mm  [2][64];
    logic [3:0]  bad [2][64];
    int          rem [2];
    logic [31:0] erd [2][2];
    logic [1:0]  ev  [2];
    logic [1:0]  ep  [2];

    always #5 clk = ~clk;

    sram_1w_nr_init #(.DATA_W(32), .DEPTH(64), .ADDR_W(6), .NRD(2), .WT_BYPASS(1)) u_wt (
        .clk(clk), .rst(rst), .init_req(init_req), .busy(busy_o[0]),
        .wen(wen), .waddr(waddr), .wbe(wbe), .wdata(wdata),
        .ren(ren), .raddr(raddr), .rdata(rdata_o[0]), .rvalid(rvalid_o[0])
`ifdef SRAM_PARITY_EN
        , .perr_inject(perr_inject), .rperr(rperr_o[0])
`endif
    );

    sram_1w_nr_init #(.DATA_W(32), .DEPTH(48), .ADDR_W(6), .NRD(2), .WT_BYPASS(0)) u_ro (
        .clk(clk), .rst(rst), .init_req(init_req), .busy(busy_o[1]),
        .wen(wen), .waddr(waddr), .wbe(wbe), .wdata(wdata),
        .ren(ren), .raddr(raddr), .rdata(rdata_o[1]), .rvalid(rvalid_o[1])
`ifdef SRAM_PARITY_EN
        , .perr_inject(perr_inject), .rperr(rperr_o[1])
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic clear_model(input int i);
        for (int a = 0; a < 64; a++) begin
            mm[i][a]  = '0;
            bad[i][a] = '0;
        end
    endtask

    task automatic idle();
        init_req = 1'b0; wen = 1'b0; wbe = '0; ren = '0; perr_inject = 1'b0;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check(i == 0 ? "wt_busy" : "ro_busy", 64'(busy_o[i]), 64'(rem[i] > 0));
            check(i == 0 ? "wt_rvalid" : "ro_rvalid", 64'(rvalid_o[i]), 64'(ev[i]));
            check(i == 0 ? "wt_rdata" : "ro_rdata", rdata_o[i], {erd[i][1], erd[i][0]});
`ifdef SRAM_PARITY_EN
            check(i == 0 ? "wt_rperr" : "ro_rperr", 64'(rperr_o[i]), 64'(ep[i]));
`endif
        end
    endtask

    // One clock: update the model with the inputs sampled at this edge, then compare.
    task automatic cyc();
        logic [5:0] ra;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rem[i] > 0) begin
                rem[i]--;
                ev[i] = '0;
                ep[i] = '0;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    ra = raddr[p*6 +: 6];
                    ev[i][p] = ren[p];
                    ep[i][p] = 1'b0;
                    if (ren[p]) begin
                        if (int'(ra) >= dep[i]) begin
                            erd[i][p] = '0;
                        end else if (byp[i] && wen && waddr == ra) begin
                            erd[i][p] = merge(mm[i][ra], wdata, wbe);
                            ep[i][p]  = |((bad[i][ra] & ~wbe) | (wbe & {4{perr_inject}}));
                        end else begin
                            erd[i][p] = mm[i][ra];
                            ep[i][p]  = |bad[i][ra];
                        end
                    end
                end
                if (wen && int'(waddr) < dep[i]) begin
                    mm[i][waddr]  = merge(mm[i][waddr], wdata, wbe);
                    bad[i][waddr] = (bad[i][waddr] & ~wbe) | (wbe & {4{perr_inject}});
                end
                if (init_req) begin
                    rem[i] = dep[i];
                    clear_model(i);
                end
            end
        end
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        for (int i = 0; i < 2; i++) begin
            rem[i] = dep[i];
            ev[i]  = '0;
            ep[i]  = '0;
            erd[i][0] = '0;
            erd[i][1] = '0;
            clear_model(i);
        end
        #2;
        compare_all();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic count_busy();
        n = 0;
        while (busy_o[0] && n < 200) begin
            cyc();
            n++;
        end
        check("busy_len", 64'(n), 64'd64);
    endtask

    task automatic read_all();
        for (int a = 0; a < 64; a++) begin
            idle();
            ren = 2'b11;
            raddr = {6'(63 - a), 6'(a)};
            cyc();
        end
        idle();
        cyc();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        do_reset();
        count_busy();
        read_all();

        // byte-merge on repeated writes
        idle(); wen = 1'b1; waddr = 6'd5; wbe = 4'b1111; wdata = 32'hDEADBEEF; cyc();
        wbe = 4'b0010; wdata = 32'h0000AA00; cyc();
        idle(); ren = 2'b01; raddr = {6'd0, 6'd5}; cyc();
        check("merge", 64'(rdata_o[0][31:0]), 64'h DEADAAEF);

        // same-address collision on both ports
        idle(); wen = 1'b1; waddr = 6'd9; wbe = 4'b1111; wdata = 32'h11111111; cyc();
        wbe = 4'b0011; wdata = 32'h22222222; ren = 2'b11; raddr = {6'd9, 6'd9}; cyc();
        check("coll_wt", rdata_o[0], 64'h11112222_11112222);
        check("coll_ro", rdata_o[1], 64'h11111111_11111111);
        idle(); cyc();

        // fill with address value, then per-port valid and hold
        for (int a = 0; a < 64; a++) begin
            idle(); wen = 1'b1; waddr = 6'(a); wbe = 4'hF; wdata = 32'(a); cyc();
        end
        idle(); ren = 2'b11; raddr = {6'd63, 6'd3}; cyc();
        check("rv_both", 64'(rvalid_o[0]), 64'b11);
        ren = 2'b01; raddr = {6'd10, 6'd3}; cyc();
        check("rv_p0", 64'(rvalid_o[0]), 64'b01);
        check("hold_p1", 64'(rdata_o[0][63:32]), 64'd63);

        // re-init, then reset in the middle of it
        idle(); init_req = 1'b1; cyc();
        idle();
        for (int k = 0; k < 19; k++) cyc();
        do_reset();
        count_busy();
        read_all();

`ifdef SRAM_PARITY_EN
        idle(); wen = 1'b1; waddr = 6'd7; wbe = 4'hF; wdata = 32'h0F0F1234; perr_inject = 1'b1; cyc();
        idle(); ren = 2'b01; raddr = {6'd0, 6'd7}; cyc();
        check("perr_set", 64'(rperr_o[0][0]), 64'd1);
        idle(); wen = 1'b1; waddr = 6'd7; wbe = 4'hF; wdata = 32'h0F0F1234; cyc();
        idle(); ren = 2'b01; raddr = {6'd0, 6'd7}; cyc();
        check("perr_clr", 64'(rperr_o[0][0]), 64'd0);
`endif

        // random traffic, narrow address range to provoke collisions
        for (int k = 0; k < 3000; k++) begin
            init_req = $urandom_range(0, 299) == 0;
            wen   = $urandom_range(0, 1) == 1;
            waddr = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom);
            wbe   = 4'($urandom);
            wdata = $urandom;
            ren   = 2'($urandom);
            raddr = ($urandom_range(0, 1) == 1) ? {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))} : 12'($urandom);
`ifdef SRAM_PARITY_EN
            perr_inject = $urandom_range(0, 7) == 0;
`endif
            cyc();
            if (k == 1500) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
